// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, FSM state type and byte-enable helper for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // func3[1:0] encodes the access size for both signed and unsigned loads
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/grant/response data-memory bus between the LSU and memory
interface lsu_if;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;

    modport master (
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_gnt, m_rvalid, m_rdata, m_err
    );

    modport slave (
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_gnt, m_rvalid, m_rdata, m_err
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication, byte-enable generation and load shift/extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] sh;

    always_comb begin
        be_o = byte_en(func3_i, off_i);
        sh   = rdata_i >> {off_i, 3'b000};

        case (func3_i[1:0])
            2'b00:   wdata_o = {4{store_data_i[7:0]}};
            2'b01:   wdata_o = {2{store_data_i[15:0]}};
            default: wdata_o = store_data_i;
        endcase

        case (func3_i)
            F3_B:    load_data_o = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   load_data_o = {24'd0, sh[7:0]};
            F3_H:    load_data_o = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   load_data_o = {16'd0, sh[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: alignment checks, memory handshake FSM and timeout
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        exc_misaligned_o,
    output logic        exc_fault_o,
    lsu_if.master       mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    lsu_state_e    state_q;
    logic [31:0]   addr_q;
    logic [2:0]    func3_q;
    logic          we_q;
    logic [31:0]   sdata_q;
    logic          err_q;
    logic [31:0]   load_data_q;
    logic [CW-1:0] cnt_q;

    logic        access, illegal, misaligned, in_idle, accept;
    logic [3:0]  be;
    logic [31:0] wdata, ext_data;

    lsu_align u_align (
        .func3_i      (func3_q),
        .off_i        (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (mem.m_rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (ext_data)
    );

    always_comb begin
        access     = ex_valid_i && (mem_read_i || mem_write_i);
        illegal    = (func3_i == 3'b011) || (func3_i[2:1] == 2'b11) || (mem_write_i && func3_i[2]);
        misaligned = (func3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (func3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        in_idle    = (state_q == IDLE);
        accept     = in_idle && access && !illegal && !misaligned;
    end

    assign stall_o          = accept || (state_q == REQ) || (state_q == RESP);
    assign exc_misaligned_o = in_idle && access && !illegal && misaligned;
    assign exc_fault_o      = (in_idle && access && illegal) || (state_q == DONE && err_q);
    assign load_valid_o     = (state_q == DONE) && !we_q && !err_q;
    assign load_data_o      = load_data_q;

    assign mem.m_req   = (state_q == REQ);
    assign mem.m_we    = (state_q == REQ) && we_q;
    assign mem.m_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.m_be    = (state_q == REQ) ? be : 4'd0;
    assign mem.m_wdata = (state_q == REQ) ? wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            func3_q     <= '0;
            we_q        <= 1'b0;
            sdata_q     <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            // Counter saturates so a grant on the last budgeted cycle still times out in RESP
            if ((state_q == REQ || state_q == RESP) && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= addr_i;
                        func3_q <= func3_i;
                        we_q    <= mem_write_i;
                        sdata_q <= store_data_i;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem.m_gnt) begin
                        state_q <= RESP;
                    end else if (cnt_q == CNT_MAX) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RESP: begin
                    if (mem.m_rvalid) begin
                        err_q <= mem.m_err;
                        if (!we_q)
                            load_data_q <= ext_data;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
